// File: rtl/bridge_unpack.sv
// bridge_unpack: width-narrowing stage. It takes M-bit words over valid/ready
// and treats them as one continuous LSB-first bit stream. It emits N-bit beats
// over valid/ready. A word flagged with last_i flushes the residual bits as a
// zero-padded final beat, and that beat carries last_o.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   vld_i      input word valid
//   din[M]     input word, bit 0 is first in stream order
//   last_i     input word is the final word of a packet (qualified by vld_i)
//   rdy_o      block can accept a word this cycle
//   vld_o      output beat valid
//   dout[N]    output beat, bit 0 is the oldest stream bit
//   last_o     beat is the final beat of the packet
//   rdy_i      downstream ready
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. rdy_o depends only on registered state. Once vld_o is raised it
// stays high, with dout and last_o stable, until the beat is taken. Inputs are
// ignored while rdy_o is low.
module bridge_unpack #(
  parameter int M = 11,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [M-1:0] din,
  input  logic         last_i,
  output logic         rdy_o,
  output logic         vld_o,
  output logic [N-1:0] dout,
  output logic         last_o,
  input  logic         rdy_i
);

  // A word is only accepted while fewer than N bits are held, so at most
  // N-1 old bits plus M new bits are ever stored.
  localparam int BUF = M + N - 1;
  localparam int CW  = $clog2(BUF + 1);

  logic [BUF-1:0] r_buf;
  logic [CW-1:0]  r_cnt;
  logic           r_flush;

  logic           w_accept;
  logic           w_fire;
  logic [BUF-1:0] w_din_ext;
  logic [BUF-1:0] w_ins_mask;

  assign rdy_o    = (r_cnt < CW'(N)) && !r_flush;
  assign vld_o    = (r_cnt >= CW'(N)) || (r_flush && (r_cnt != '0));
  assign last_o   = r_flush && (r_cnt <= CW'(N)) && vld_o;
  assign w_accept = vld_i && rdy_o;
  assign w_fire   = vld_o && rdy_i;

  // Zero-extended word and its lane mask, positioned later by r_cnt.
  always_comb begin
    w_din_ext          = '0;
    w_din_ext[M-1:0]   = din;
    w_ins_mask         = '0;
    w_ins_mask[M-1:0]  = {M{1'b1}};
  end

  // Bits at or above r_cnt are not stream data; they are forced to zero so a
  // short final beat is zero-padded.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      dout[i] = r_buf[i] && (CW'(i) < r_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else if (w_accept) begin
      r_buf   <= (r_buf & ~(w_ins_mask << r_cnt)) | (w_din_ext << r_cnt);
      r_cnt   <= r_cnt + CW'(M);
      r_flush <= last_i;
    end else if (w_fire) begin
      r_buf <= r_buf >> N;
      r_cnt <= (r_cnt > CW'(N)) ? (r_cnt - CW'(N)) : '0;
      if (last_o) begin
        r_flush <= 1'b0;
      end
    end
  end

endmodule
